// File: rtl/pixel_packer_mono8.sv
// Mono8 return-path packer: gathers a frame of 8-bit pixels into 256-bit
// AXI-Stream beats, with a partial-keep tlast beat at the end of each frame.
module pixel_packer_mono8 #(
  parameter int OUT_ROWS         = 20,
  parameter int OUT_COLS         = 20,
  parameter int PIXELS_PER_BURST = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  output logic                          ap_idle,
  output logic                          ap_done,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [7:0]                    s_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [8*PIXELS_PER_BURST-1:0] m_axis_tdata,
  output logic [PIXELS_PER_BURST-1:0]   m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a transfer happens on any rising clk edge where valid and
  // ready are both high; valid never waits on ready, and the master side holds
  // data/keep/last stable while valid is high and ready is low.

  localparam int N  = OUT_ROWS * OUT_COLS;
  localparam int CW = $clog2(N + 1);
  localparam int LW = $clog2(PIXELS_PER_BURST);
  localparam int DW = 8 * PIXELS_PER_BURST;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [LW-1:0] LANE_MAX = LW'(PIXELS_PER_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LW-1:0]           lane;
  logic [CW-1:0]           pixel_cnt;
  logic [DW-1:0]           asm_data;
  logic [DW-1:0]           asm_merged;
  logic [DW-1:0]           beat_data;
  logic [PIXELS_PER_BURST-1:0] beat_keep;

  logic closing_pixel;
  logic out_blocked;
  logic accept;
  logic close_beat;
  logic last_pixel;
  logic m_hs;

  assign closing_pixel = (lane == LANE_MAX) || (pixel_cnt == LAST_IDX);
  assign out_blocked   = m_axis_tvalid && !m_axis_tready;

  // Only the pixel that would overwrite a still-pending beat is held back;
  // every other pixel flows at one per clock while the output waits.
  assign s_axis_tready = (state == S_PACK) && !(s_axis_tvalid && closing_pixel && out_blocked);

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign close_beat = accept && closing_pixel;
  assign last_pixel = accept && (pixel_cnt == LAST_IDX);
  assign m_hs       = m_axis_tvalid && m_axis_tready;

  assign ap_idle   = (state == S_IDLE);
  assign ap_done   = (state == S_DONE);
  assign dbg_state = state;

  // Assembly bytes with the current pixel merged in, and lanes past the
  // current one zeroed so a short final beat carries no stale bytes.
  always_comb begin
    asm_merged = asm_data;
    asm_merged[8*int'(lane) +: 8] = s_axis_tdata;
    beat_keep = '0;
    beat_data = '0;
    for (int i = 0; i < PIXELS_PER_BURST; i++) begin
      beat_keep[i] = (i <= int'(lane));
      beat_data[8*i +: 8] = beat_keep[i] ? asm_merged[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start) state_nxt = S_PACK;
      S_PACK:  if (last_pixel) state_nxt = S_DRAIN;
      S_DRAIN: if (m_hs && m_axis_tlast) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      lane      <= '0;
      pixel_cnt <= '0;
      asm_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && ap_start) begin
        lane      <= '0;
        pixel_cnt <= '0;
        asm_data  <= '0;
      end else if (accept) begin
        pixel_cnt <= pixel_cnt + CW'(1);
        lane      <= close_beat ? '0 : lane + LW'(1);
        asm_data  <= asm_merged;
      end
    end
  end

  // A newly closed beat takes priority over clearing valid, so a handshake and
  // a load in the same cycle swap beats without a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (close_beat) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= beat_data;
      m_axis_tkeep  <= beat_keep;
      m_axis_tlast  <= last_pixel;
    end else if (m_hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_packer_mono8.sv
// Bench for pixel_packer_mono8: default 20x20 instance for frame-level tests,
// plus a 4x16 instance for the output back-pressure scenario.
module tb_pixel_packer_mono8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default-geometry instance (N = 400)
  logic         ap_start, ap_idle, ap_done;
  logic         s_axis_tvalid, s_axis_tready;
  logic [7:0]   s_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [1:0]   dbg_state;

  // 4x16 instance (N = 64)
  logic         b_start, b_idle, b_done;
  logic         b_svalid, b_sready;
  logic [7:0]   b_sdata;
  logic         b_mvalid, b_mready;
  logic [255:0] b_mdata;
  logic [31:0]  b_mkeep;
  logic         b_mlast;
  logic [1:0]   b_dbg_state;

  pixel_packer_mono8 dut (
    .clk(clk), .reset(rst_n),
    .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .dbg_state(dbg_state)
  );

  pixel_packer_mono8 #(.OUT_ROWS(4), .OUT_COLS(16)) dut_small (
    .clk(clk), .reset(rst_n),
    .ap_start(b_start), .ap_idle(b_idle), .ap_done(b_done),
    .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready), .s_axis_tdata(b_sdata),
    .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready), .m_axis_tdata(b_mdata),
    .m_axis_tkeep(b_mkeep), .m_axis_tlast(b_mlast), .dbg_state(b_dbg_state)
  );

  localparam int NPIX = 400;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   exp_q[$];
  logic [7:0]   src_q[$];
  logic [255:0] bd_q[$];
  logic [31:0]  bk_q[$];
  logic         bl_q[$];
  int cyc, acc_cnt, done_cnt, done_cyc, last_hs_cyc, tlast_cnt;

  // Reference model: beat k of the frame held in exp_q.
  function automatic void model_beat(input int k, output logic [255:0] d,
                                     output logic [31:0] kp, output logic l);
    int n;
    n  = exp_q.size();
    d  = '0;
    kp = '0;
    for (int i = 0; i < 32; i++) begin
      if (32*k + i < n) begin
        d[8*i +: 8] = exp_q[32*k + i];
        kp[i] = 1'b1;
      end
    end
    l = (32*k + 32 >= n);
  endfunction

  task automatic clear_capture();
    bd_q = {}; bk_q = {}; bl_q = {};
    acc_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; tlast_cnt = 0;
  endtask

  // One clock of the default instance: drive after posedge, sample at negedge.
  task automatic tick(input int vpct, input int rpct);
    s_axis_tvalid = (src_q.size() > 0) && (int'($urandom_range(99)) < vpct);
    s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    m_axis_tready = (int'($urandom_range(99)) < rpct);
    @(negedge clk);
    cyc++;
    if (s_axis_tvalid && s_axis_tready) begin
      void'(src_q.pop_front());
      acc_cnt++;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      bd_q.push_back(m_axis_tdata);
      bk_q.push_back(m_axis_tkeep);
      bl_q.push_back(m_axis_tlast);
      if (m_axis_tlast) begin
        tlast_cnt++;
        last_hs_cyc = cyc;
      end
    end
    if (ap_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int vpct, input int rpct, input int budget);
    int d0;
    int g;
    d0 = done_cnt;
    g  = 0;
    ap_start = 1'b1;
    tick(vpct, rpct);
    ap_start = 1'b0;
    while (done_cnt == d0 && g < budget) begin
      tick(vpct, rpct);
      g++;
    end
    n_checks++;
    if (done_cnt == d0) $display("FAIL frame_timeout: got no ap_done within %0d cycles, required ap_done", budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++; if (ap_idle !== 1'b1) $display("FAIL rst_ap_idle: got %b required 1", ap_idle); else n_pass++;
    n_checks++; if (ap_done !== 1'b0) $display("FAIL rst_ap_done: got %b required 0", ap_done); else n_pass++;
    n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL rst_s_tready: got %b required 0", s_axis_tready); else n_pass++;
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b required 0", m_axis_tvalid); else n_pass++;
    n_checks++; if (m_axis_tdata !== 256'h0) $display("FAIL rst_m_tdata: got %h required 0", m_axis_tdata); else n_pass++;
    n_checks++; if (m_axis_tkeep !== 32'h0) $display("FAIL rst_m_tkeep: got %h required 0", m_axis_tkeep); else n_pass++;
    n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL rst_m_tlast: got %b required 0", m_axis_tlast); else n_pass++;
    n_checks++; if (b_idle !== 1'b1) $display("FAIL rst_small_idle: got %b required 1", b_idle); else n_pass++;
  endtask

  task automatic test_full_frame();
    logic [255:0] ed;
    logic [31:0]  ek;
    logic         el;
    clear_capture();
    exp_q = {};
    for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(i));
    src_q = exp_q;
    run_frame(100, 100, 1000);
    n_checks++; if (bd_q.size() != 13) $display("FAIL full_beat_count: got %0d required 13", bd_q.size()); else n_pass++;
    for (int k = 0; k < bd_q.size(); k++) begin
      model_beat(k, ed, ek, el);
      n_checks++; if (bd_q[k] !== ed) $display("FAIL full_data beat %0d: got %h required %h", k, bd_q[k], ed); else n_pass++;
      n_checks++; if (bk_q[k] !== ek) $display("FAIL full_keep beat %0d: got %h required %h", k, bk_q[k], ek); else n_pass++;
      n_checks++; if (bl_q[k] !== el) $display("FAIL full_last beat %0d: got %b required %b", k, bl_q[k], el); else n_pass++;
    end
    n_checks++; if (bk_q[12] !== 32'h0000FFFF) $display("FAIL full_last_keep: got %h required 0000ffff", bk_q[12]); else n_pass++;
    n_checks++; if (bd_q[12][7:0] !== 8'h80) $display("FAIL full_last_byte0: got %h required 80", bd_q[12][7:0]); else n_pass++;
    n_checks++; if (bd_q[12][255:128] !== 128'h0) $display("FAIL full_last_pad: got %h required 0", bd_q[12][255:128]); else n_pass++;
    n_checks++; if (done_cyc != last_hs_cyc + 1) $display("FAIL full_done_timing: got cycle %0d required %0d", done_cyc, last_hs_cyc + 1); else n_pass++;
  endtask

  task automatic test_stall();
    int idx, beats, ready_bad, stall_cycles, stall_ready_hi, unstable;
    bit held, done_seen;
    logic [255:0] held_data, e0, e1;
    logic [255:0] got_d[2];
    logic [31:0]  got_k[2];
    logic         got_l[2];
    idx = 0; beats = 0; ready_bad = 0; stall_cycles = 0; stall_ready_hi = 0; unstable = 0;
    held = 1'b0; done_seen = 1'b0; held_data = '0;
    b_start = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      b_mready = (c >= 80);
      b_svalid = (idx < 64);
      b_sdata  = 8'(idx);
      @(negedge clk);
      if (idx < 63 && !b_sready) ready_bad++;
      if (idx == 63 && c < 80) begin
        stall_cycles++;
        if (b_sready) stall_ready_hi++;
      end
      if (b_mvalid && !b_mready) begin
        if (!held) begin held = 1'b1; held_data = b_mdata; end
        else if (b_mdata !== held_data) unstable++;
      end
      if (b_mvalid && b_mready) begin
        if (beats < 2) begin
          got_d[beats] = b_mdata; got_k[beats] = b_mkeep; got_l[beats] = b_mlast;
        end
        beats++;
      end
      if (b_done) done_seen = 1'b1;
      if (b_svalid && b_sready) idx++;
      @(posedge clk); #1;
    end
    b_svalid = 1'b0;
    b_mready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      e0[8*i +: 8] = 8'(i);
      e1[8*i +: 8] = 8'(i + 32);
    end
    n_checks++; if (ready_bad != 0) $display("FAIL stall_early_ready: got %0d low cycles required 0", ready_bad); else n_pass++;
    n_checks++; if (stall_cycles == 0 || stall_ready_hi != 0) $display("FAIL stall_pix63_ready: got %0d high of %0d cycles required 0 high", stall_ready_hi, stall_cycles); else n_pass++;
    n_checks++; if (unstable != 0) $display("FAIL stall_beat0_stable: got %0d changes required 0", unstable); else n_pass++;
    n_checks++; if (beats != 2) $display("FAIL stall_beat_count: got %0d required 2", beats); else n_pass++;
    n_checks++; if (got_d[0] !== e0 || got_k[0] !== 32'hFFFFFFFF || got_l[0] !== 1'b0) $display("FAIL stall_beat0: got %h/%h/%b required %h/ffffffff/0", got_d[0], got_k[0], got_l[0], e0); else n_pass++;
    n_checks++; if (got_d[1] !== e1 || got_k[1] !== 32'hFFFFFFFF || got_l[1] !== 1'b1) $display("FAIL stall_beat1: got %h/%h/%b required %h/ffffffff/1", got_d[1], got_k[1], got_l[1], e1); else n_pass++;
    n_checks++; if (!done_seen) $display("FAIL stall_done: got no ap_done required one"); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] got_q[$];
    int bad_idx;
    for (int f = 0; f < 3; f++) begin
      clear_capture();
      exp_q = {};
      for (int i = 0; i < NPIX; i++) exp_q.push_back(8'($urandom));
      src_q = exp_q;
      run_frame(70, 60, 4000);
      repeat (5) tick(70, 60);
      got_q = {};
      for (int k = 0; k < bd_q.size(); k++)
        for (int i = 0; i < 32; i++)
          if (bk_q[k][i]) got_q.push_back(bd_q[k][8*i +: 8]);
      bad_idx = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (bad_idx < 0 && got_q[i] !== exp_q[i]) bad_idx = i;
      n_checks++; if (got_q.size() != NPIX) $display("FAIL rand_byte_count frame %0d: got %0d required %0d", f, got_q.size(), NPIX); else n_pass++;
      n_checks++; if (bad_idx >= 0) $display("FAIL rand_bytes frame %0d: byte %0d got %h required %h", f, bad_idx, got_q[bad_idx], exp_q[bad_idx]); else n_pass++;
      n_checks++; if (tlast_cnt != 1) $display("FAIL rand_tlast frame %0d: got %0d required 1", f, tlast_cnt); else n_pass++;
      n_checks++; if (done_cnt != 1) $display("FAIL rand_done frame %0d: got %0d required 1", f, done_cnt); else n_pass++;
    end
  endtask

  task automatic test_start_mid();
    int g;
    clear_capture();
    exp_q = {};
    for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(i));
    src_q = exp_q;
    ap_start = 1'b1;
    tick(100, 100);
    ap_start = 1'b0;
    g = 0;
    while (acc_cnt < 101 && g < 500) begin tick(100, 100); g++; end
    ap_start = 1'b1;
    tick(100, 100);
    ap_start = 1'b0;
    g = 0;
    while (done_cnt == 0 && g < 1000) begin tick(100, 100); g++; end
    n_checks++; if (acc_cnt != NPIX) $display("FAIL mid_start_accepted: got %0d required %0d", acc_cnt, NPIX); else n_pass++;
    n_checks++; if (bd_q.size() != 13 || tlast_cnt != 1) $display("FAIL mid_start_beats: got %0d beats %0d tlast required 13/1", bd_q.size(), tlast_cnt); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL mid_start_done: got %0d required 1", done_cnt); else n_pass++;
    for (int i = 0; i < 5; i++) src_q.push_back(8'hA5);
    repeat (10) tick(100, 100);
    n_checks++; if (acc_cnt != NPIX || src_q.size() != 5) $display("FAIL extra_pixels: got %0d accepted required %0d", acc_cnt, NPIX); else n_pass++;
    src_q = {};
  endtask

  task automatic test_reset_mid();
    logic [255:0] ed;
    logic [31:0]  ek;
    logic         el;
    int g;
    clear_capture();
    exp_q = {};
    for (int i = 0; i < NPIX; i++) exp_q.push_back(8'($urandom));
    src_q = exp_q;
    ap_start = 1'b1;
    tick(100, 0);
    ap_start = 1'b0;
    g = 0;
    while (acc_cnt < 51 && g < 500) begin tick(100, 0); g++; end
    n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL pre_reset_valid: got %b required 1", m_axis_tvalid); else n_pass++;
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL mid_reset_valid: got %b required 0", m_axis_tvalid); else n_pass++;
    n_checks++; if (ap_idle !== 1'b1) $display("FAIL mid_reset_idle: got %b required 1", ap_idle); else n_pass++;
    n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL mid_reset_ready: got %b required 0", s_axis_tready); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_capture();
    exp_q = {};
    for (int i = 0; i < NPIX; i++) exp_q.push_back(8'($urandom));
    src_q = exp_q;
    run_frame(100, 100, 1000);
    n_checks++; if (bd_q[0][7:0] !== exp_q[0]) $display("FAIL post_reset_byte0: got %h required %h", bd_q[0][7:0], exp_q[0]); else n_pass++;
    n_checks++; if (bd_q.size() != 13) $display("FAIL post_reset_beats: got %0d required 13", bd_q.size()); else n_pass++;
    for (int k = 0; k < bd_q.size(); k++) begin
      model_beat(k, ed, ek, el);
      n_checks++;
      if (bd_q[k] !== ed || bk_q[k] !== ek || bl_q[k] !== el)
        $display("FAIL post_reset_beat %0d: got %h/%h/%b required %h/%h/%b", k, bd_q[k], bk_q[k], bl_q[k], ed, ek, el);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]   f2_q[$];
    logic [255:0] ed;
    logic [31:0]  ek;
    logic         el;
    bit started2;
    int g;
    clear_capture();
    f2_q = {};
    for (int i = 0; i < NPIX; i++) f2_q.push_back(8'($urandom));
    src_q = {};
    for (int i = 0; i < NPIX; i++) src_q.push_back(8'hFF);
    for (int i = 0; i < NPIX; i++) src_q.push_back(f2_q[i]);
    started2 = 1'b0;
    ap_start = 1'b1;
    tick(100, 100);
    ap_start = 1'b0;
    g = 0;
    while (done_cnt < 2 && g < 2000) begin
      ap_start = (done_cnt == 1) && !started2;
      tick(100, 100);
      if (ap_start) started2 = 1'b1;
      ap_start = 1'b0;
      g++;
    end
    n_checks++; if (done_cnt != 2) $display("FAIL b2b_done: got %0d required 2", done_cnt); else n_pass++;
    n_checks++; if (bd_q.size() != 26) $display("FAIL b2b_beats: got %0d required 26", bd_q.size()); else n_pass++;
    exp_q = f2_q;
    for (int k = 13; k < bd_q.size(); k++) begin
      model_beat(k - 13, ed, ek, el);
      n_checks++;
      if (bd_q[k] !== ed || bk_q[k] !== ek || bl_q[k] !== el)
        $display("FAIL b2b_beat %0d: got %h/%h/%b required %h/%h/%b", k - 13, bd_q[k], bk_q[k], bl_q[k], ed, ek, el);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ap_start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; m_axis_tready = 1'b0;
    b_start = 1'b0; b_svalid = 1'b0; b_sdata = 8'h00; b_mready = 1'b0;
    cyc = 0;
    clear_capture();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_full_frame();
    test_stall();
    test_random();
    test_start_mid();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
